stage_sequencer: RTL

Parametrised multi-cycle stage sequencer, the successor to the core's fixed seven-stage FSM. It drives one-hot stage activation through `NUM_STAGES` stages and chooses the per-instruction control operation (normal, trap, interrupt, halt). It also adds:
- a per-instruction stage-skip mask;
- prioritised fault and interrupt vectors;
- a per-stage watchdog;
- double-fault detection;
- a retire pulse.

It sits between the datapath's stage-done signals and every enable in the core.

---
 rtl/stage_sequencer_pkg.sv | 27 ++
 rtl/stage_sequencer_if.sv | 49 ++++
 rtl/stage_sequencer_prio_enc.sv | 29 ++
 rtl/stage_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// stage_seq_pkg
// Shared constants for the stage sequencer: the control_op encodings, the
// position of the CONTROL stage in the one-hot stage vector, the offset added
// to NUM_FAULTS to form the watchdog cause, and a helper that sizes the cause
// field.
// ---------------------------------------------------------------------------
package stage_seq_pkg;

   // Operation chosen in CONTROL for the sequence that follows
   localparam logic [1:0] OP_TRAP   = 2'b00;
   localparam logic [1:0] OP_IRQ    = 2'b01;
   localparam logic [1:0] OP_HALT   = 2'b10;
   localparam logic [1:0] OP_NORMAL = 2'b11;

   // CONTROL is always bit 0 of the one-hot stage vector
   localparam int STAGE_CONTROL = 0;

   // The watchdog cause sits just above the external fault causes
   localparam int WD_CAUSE_OFFSET = 0;

   // Cause field must hold every fault index, the watchdog cause and irq indices
   function automatic int causeWidth(input int numFaults);
      return $clog2(numFaults + 2);
   endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// stage_sequencer_if
// Bundles everything between the stage sequencer and the datapath.
//   Datapath -> sequencer : stage_done, stage_skip, fault_vec, irq,
//                           irq_enable, halt_req
//   Sequencer -> datapath : stage_active, control_op, cause, cause_is_irq,
//                           instret, halted, double_fault
// Modports:
//   master : the sequencer (drives stage enables and status)
//   slave  : the datapath / core side
// ---------------------------------------------------------------------------
interface stage_sequencer_if
   import stage_seq_pkg::*;
#(
   parameter int NUM_STAGES = 7,
   parameter int NUM_FAULTS = 4,
   parameter int NUM_IRQ    = 2
) ();

   localparam int CW = causeWidth(NUM_FAULTS);

   logic [NUM_STAGES-1:0] stage_done;
   logic [NUM_STAGES-1:0] stage_skip;
   logic [NUM_FAULTS-1:0] fault_vec;
   logic [NUM_IRQ-1:0]    irq;
   logic                  irq_enable;
   logic                  halt_req;

   logic [NUM_STAGES-1:0] stage_active;
   logic [1:0]            control_op;
   logic [CW-1:0]         cause;
   logic                  cause_is_irq;
   logic                  instret;
   logic                  halted;
   logic                  double_fault;

   modport master (
      input  stage_done, stage_skip, fault_vec, irq, irq_enable, halt_req,
      output stage_active, control_op, cause, cause_is_irq, instret, halted,
             double_fault
   );

   modport slave (
      output stage_done, stage_skip, fault_vec, irq, irq_enable, halt_req,
      input  stage_active, control_op, cause, cause_is_irq, instret, halted,
             double_fault
   );

endinterface

// File: rtl/stage_sequencer_prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc
// Lowest-index-wins priority encoder.
//   req_i   : request vector
//   idx_o   : index of the lowest set request (0 when none)
//   valid_o : at least one request is set
// ---------------------------------------------------------------------------
module prio_enc #(
   parameter int WIDTH = 4,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle stage sequencer. Walks a one-hot activation through NUM_STAGES
// stages, skipping post-decode stages on request, and picks the operation of
// each sequence (normal, trap, irq, halt) in the CONTROL stage.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : stage_sequencer_if.master (stage done/skip, faults, irqs, halt
//           request in; stage enables, op, cause and status flags out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int NUM_STAGES   = 7,
   parameter int DECODE_STAGE = 2,
   parameter int NUM_FAULTS   = 4,
   parameter int NUM_IRQ      = 2,
   parameter int TIMEOUT      = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   stage_sequencer_if.master    bus
);

   localparam int CW  = causeWidth(NUM_FAULTS);
   localparam int FIW = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
   localparam int IIW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [NUM_STAGES-1:0] ONEHOT_CONTROL = NUM_STAGES'(1) << STAGE_CONTROL;
   localparam logic [NUM_STAGES-1:0] ONEHOT_FIRST   = NUM_STAGES'(1) << (STAGE_CONTROL + 1);
   localparam logic [CW-1:0]         WD_CAUSE       = CW'(NUM_FAULTS + WD_CAUSE_OFFSET);

   logic [NUM_STAGES-1:0] stageActive_q, stageActive_d;
   logic [1:0]            controlOp_q, controlOp_d;
   logic [CW-1:0]         cause_q, cause_d;
   logic                  causeIsIrq_q, causeIsIrq_d;
   logic                  instret_q, instret_d;
   logic                  halted_q, halted_d;
   logic                  doubleFault_q, doubleFault_d;
   logic                  faultPend_q, faultPend_d;
   logic [CW-1:0]         faultCause_q, faultCause_d;
   logic [WDW-1:0]        wdCount_q, wdCount_d;

   logic [FIW-1:0]        faultIdx;
   logic                  faultValid;
   logic [IIW-1:0]        irqIdx;
   logic                  irqValid;

   logic                  inControl;
   logic                  activeDone;
   logic                  wdFire;
   logic                  anyFault;
   logic [CW-1:0]         faultCode;
   logic [NUM_STAGES-1:0] skipAllow;
   logic [NUM_STAGES-1:0] upperStages;
   logic [NUM_STAGES-1:0] aboveMask;
   logic [NUM_STAGES-1:0] candidates;
   logic [NUM_STAGES-1:0] nextStage;

   prio_enc #(.WIDTH(NUM_FAULTS), .IDX_W(FIW)) faultEnc (
      .req_i   (bus.fault_vec),
      .idx_o   (faultIdx),
      .valid_o (faultValid)
   );

   prio_enc #(.WIDTH(NUM_IRQ), .IDX_W(IIW)) irqEnc (
      .req_i   (bus.irq),
      .idx_o   (irqIdx),
      .valid_o (irqValid)
   );

   // Only stages strictly between decode and write-back may be skipped;
   // the skip bits for CONTROL, the front end and write-back are masked off.
   always_comb begin
      skipAllow = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         skipAllow[j] = (j > DECODE_STAGE) && (j < NUM_STAGES - 1);
      end
   end

   // Next-stage search. For a one-hot current stage s, ~((s << 1) - 1) marks
   // every index above it (and is zero when s is write-back, because the
   // shift falls off the top). Removing skipped stages and isolating the
   // lowest remaining bit gives the next stage; zero means "back to CONTROL".
   always_comb begin
      upperStages = stageActive_q << 1;
      aboveMask   = ~(upperStages - NUM_STAGES'(1));
      candidates  = aboveMask & ~(bus.stage_skip & skipAllow);
      nextStage   = candidates & (~candidates + NUM_STAGES'(1));
   end

   // Fault detection outside CONTROL. The watchdog fires on the TIMEOUT-th
   // cycle of a stage, is treated like any other fault (so it wins over a
   // same-cycle done), and loses to an external fault for the cause index.
   always_comb begin
      inControl  = stageActive_q[STAGE_CONTROL];
      activeDone = |(bus.stage_done & stageActive_q);
      wdFire     = (TIMEOUT != 0) && !inControl && (wdCount_q == WDW'(TIMEOUT - 1));
      anyFault   = !inControl && (faultValid || wdFire);
      faultCode  = faultValid ? CW'(faultIdx) : WD_CAUSE;
   end

   // Main next-state logic. CONTROL picks the operation by priority
   // (pending fault, enabled irq, halt, normal) and always leaves for stage 1
   // unless halting. A double fault parks the sequencer in CONTROL with the
   // halt op until reset. Outside CONTROL a fault beats done, and a normal
   // sequence that finishes write-back raises instret for one cycle.
   always_comb begin
      stageActive_d = stageActive_q;
      controlOp_d   = controlOp_q;
      cause_d       = cause_q;
      causeIsIrq_d  = causeIsIrq_q;
      instret_d     = 1'b0;
      halted_d      = halted_q;
      doubleFault_d = doubleFault_q;
      faultPend_d   = faultPend_q;
      faultCause_d  = faultCause_q;
      wdCount_d     = '0;

      if (inControl) begin
         if (doubleFault_q) begin
            controlOp_d = OP_HALT;
            halted_d    = 1'b1;
         end else if (faultPend_q) begin
            controlOp_d   = OP_TRAP;
            cause_d       = faultCause_q;
            causeIsIrq_d  = 1'b0;
            faultPend_d   = 1'b0;
            halted_d      = 1'b0;
            stageActive_d = ONEHOT_FIRST;
         end else if (bus.irq_enable && irqValid) begin
            controlOp_d   = OP_IRQ;
            cause_d       = CW'(irqIdx);
            causeIsIrq_d  = 1'b1;
            halted_d      = 1'b0;
            stageActive_d = ONEHOT_FIRST;
         end else if (bus.halt_req) begin
            controlOp_d = OP_HALT;
            halted_d    = 1'b1;
         end else begin
            controlOp_d   = OP_NORMAL;
            cause_d       = '0;
            causeIsIrq_d  = 1'b0;
            halted_d      = 1'b0;
            stageActive_d = ONEHOT_FIRST;
         end
      end else if (anyFault) begin
         stageActive_d = ONEHOT_CONTROL;
         if (controlOp_q == OP_NORMAL) begin
            faultPend_d  = 1'b1;
            faultCause_d = faultCode;
         end else begin
            doubleFault_d = 1'b1;
            halted_d      = 1'b1;
            controlOp_d   = OP_HALT;
         end
      end else if (activeDone) begin
         if (nextStage == '0) begin
            stageActive_d = ONEHOT_CONTROL;
            instret_d     = (controlOp_q == OP_NORMAL);
         end else begin
            stageActive_d = nextStage;
         end
      end else begin
         wdCount_d = wdCount_q + WDW'(1);
      end
   end

   // State registers with synchronous reset; reset also drops a pending fault
   always_ff @(posedge clk) begin
      if (reset) begin
         stageActive_q <= ONEHOT_CONTROL;
         controlOp_q   <= OP_NORMAL;
         cause_q       <= '0;
         causeIsIrq_q  <= 1'b0;
         instret_q     <= 1'b0;
         halted_q      <= 1'b0;
         doubleFault_q <= 1'b0;
         faultPend_q   <= 1'b0;
         faultCause_q  <= '0;
         wdCount_q     <= '0;
      end else begin
         stageActive_q <= stageActive_d;
         controlOp_q   <= controlOp_d;
         cause_q       <= cause_d;
         causeIsIrq_q  <= causeIsIrq_d;
         instret_q     <= instret_d;
         halted_q      <= halted_d;
         doubleFault_q <= doubleFault_d;
         faultPend_q   <= faultPend_d;
         faultCause_q  <= faultCause_d;
         wdCount_q     <= wdCount_d;
      end
   end

   assign bus.stage_active = stageActive_q;
   assign bus.control_op   = controlOp_q;
   assign bus.cause        = cause_q;
   assign bus.cause_is_irq = causeIsIrq_q;
   assign bus.instret      = instret_q;
   assign bus.halted       = halted_q;
   assign bus.double_fault = doubleFault_q;

endmodule
